// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared encodings for the execute stage: ALUOp classes, R-type
//             funct codes, ALU-control enum, FSM state enum and helpers for
//             ALU decode and operand forwarding.
//  Revision : 1.0  initial release
// ============================================================================
package ex_pkg;

  // ALU class codes delivered by the main decoder through ID/EX
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] c_ALUOP_OR    = 2'b11;

  // R-type function field codes understood by this stage
  localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
  localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
  localparam logic [5:0] c_FUNCT_AND = 6'b100100;
  localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
  localparam logic [5:0] c_FUNCT_SLT = 6'b101010;
  localparam logic [5:0] c_FUNCT_MUL = 6'b011000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // Map ALUOp/funct to an ALU operation; unknown funct falls back to add
  function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop,
                                           input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    case (aluop)
      c_ALUOP_ADD: ctrl = ALU_ADD;
      c_ALUOP_SUB: ctrl = ALU_SUB;
      c_ALUOP_OR:  ctrl = ALU_OR;
      c_ALUOP_RTYPE: begin
        case (funct)
          c_FUNCT_ADD: ctrl = ALU_ADD;
          c_FUNCT_SUB: ctrl = ALU_SUB;
          c_FUNCT_AND: ctrl = ALU_AND;
          c_FUNCT_OR:  ctrl = ALU_OR;
          c_FUNCT_SLT: ctrl = ALU_SLT;
          c_FUNCT_MUL: ctrl = ALU_MUL;
          default:     ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  // Pick the newest value of a source register; the younger EX/MEM result
  // beats MEM/WB, and register 0 is never forwarded
  function automatic logic [31:0] fwd_operand(input logic [4:0]  src,
                                              input logic        exm_we,
                                              input logic [4:0]  exm_rd,
                                              input logic [31:0] exm_val,
                                              input logic        wb_we,
                                              input logic [4:0]  wb_rd,
                                              input logic [31:0] wb_val,
                                              input logic [31:0] rf_val);
    if (exm_we && (exm_rd != 5'd0) && (exm_rd == src)) begin
      return exm_val;
    end
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return wb_val;
    end
    return rf_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage_if
//  Purpose  : Bundle of ID/EX inputs, MEM/WB forwarding inputs and EX/MEM
//             outputs around the execute stage.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_mem_stage_if;
  logic        start_i;
  logic        ALUSrc_i;
  logic        RegDst_i;
  logic        MemRd_i;
  logic        MemWr_i;
  logic        MemtoReg_i;
  logic        RegWrite_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] Data1_i;
  logic [31:0] Data2_i;
  logic [31:0] imm_i;
  logic [4:0]  Rs_i;
  logic [4:0]  Rt_i;
  logic [4:0]  Rd_i;
  logic [5:0]  funct_i;
  logic        WB_RegWrite_i;
  logic [4:0]  WB_Rd_i;
  logic [31:0] WB_data_i;
  logic        MemRd_o;
  logic        MemWr_o;
  logic        MemtoReg_o;
  logic        RegWrite_o;
  logic [31:0] ALUResult_o;
  logic [31:0] WrData_o;
  logic [4:0]  Rd_o;
  logic        stall_o;

  // Pipeline side that feeds the stage and consumes its results
  modport master (
    output start_i, ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i,
           RegWrite_i, ALUOp_i, Data1_i, Data2_i, imm_i, Rs_i, Rt_i, Rd_i,
           funct_i, WB_RegWrite_i, WB_Rd_i, WB_data_i,
    input  MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o, ALUResult_o, WrData_o,
           Rd_o, stall_o
  );

  // The execute stage itself
  modport slave (
    input  start_i, ALUSrc_i, RegDst_i, MemRd_i, MemWr_i, MemtoReg_i,
           RegWrite_i, ALUOp_i, Data1_i, Data2_i, imm_i, Rs_i, Rt_i, Rd_i,
           funct_i, WB_RegWrite_i, WB_Rd_i, WB_data_i,
    output MemRd_o, MemWr_o, MemtoReg_o, RegWrite_o, ALUResult_o, WrData_o,
           Rd_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage_mul.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : 32x32 shift-add multiplier, one partial product per enabled
//             cycle, 32 steps; keeps only the low 32 bits of the product.
//  Revision : 1.0  initial release
// ============================================================================
module seq_multiplier (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] prod_o
);
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic        busy_q;

  // Load operands, then add the shifted multiplicand per multiplier bit
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        a_q    <= a_i;
        b_q    <= b_i;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= acc_q + (b_q[0] ? a_q : 32'd0);
        a_q   <= {a_q[30:0], 1'b0};
        b_q   <= {1'b0, b_q[31:1]};
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign busy_o = busy_q;
  // Final step is in progress; the product is complete after this edge
  assign done_o = busy_q && (cnt_q == 5'd31);
  assign prod_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Purpose  : Execute stage with operand forwarding, ALU, iterative mul and
//             the EX/MEM pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage
  import ex_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  ex_mem_stage_if.slave bus
);
  localparam logic [1:0] c_S_IDLE = ST_IDLE;
  localparam logic [1:0] c_S_MUL  = ST_MUL;
  localparam logic [1:0] c_S_DONE = ST_DONE;

  logic [1:0]  state_q, state_d;
  logic        memrd_q, memrd_d;
  logic        memwr_q, memwr_d;
  logic        memtoreg_q, memtoreg_d;
  logic        regwrite_q, regwrite_d;
  logic [31:0] result_q, result_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  logic [4:0]  w_dst;
  alu_ctrl_e   w_alu_ctrl;
  logic        w_is_mul;
  logic        w_mul_load;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic [31:0] w_mul_prod;

  assign w_fwd_a = fwd_operand(bus.Rs_i, regwrite_q, rd_q, result_q,
                               bus.WB_RegWrite_i, bus.WB_Rd_i, bus.WB_data_i,
                               bus.Data1_i);
  assign w_fwd_b = fwd_operand(bus.Rt_i, regwrite_q, rd_q, result_q,
                               bus.WB_RegWrite_i, bus.WB_Rd_i, bus.WB_data_i,
                               bus.Data2_i);
  assign w_alu_b    = bus.ALUSrc_i ? bus.imm_i : w_fwd_b;
  assign w_dst      = bus.RegDst_i ? bus.Rd_i : bus.Rt_i;
  assign w_alu_ctrl = alu_decode(bus.ALUOp_i, bus.funct_i);
  assign w_is_mul   = (w_alu_ctrl == ALU_MUL);
  assign w_mul_load = (state_q == c_S_IDLE) && w_is_mul;

  // Single-cycle ALU; mul is handled by the iterative unit
  always_comb begin
    w_alu_res = w_fwd_a + w_alu_b;
    case (w_alu_ctrl)
      ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
      ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
      ALU_OR:  w_alu_res = w_fwd_a | w_alu_b;
      ALU_SLT: w_alu_res = {31'd0, ($signed(w_fwd_a) < $signed(w_alu_b))};
      default: w_alu_res = w_fwd_a + w_alu_b;
    endcase
  end

  seq_multiplier u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (bus.start_i),
    .load_i  (w_mul_load),
    .a_i     (w_fwd_a),
    .b_i     (w_fwd_b),
    .busy_o  (w_mul_busy),
    .done_o  (w_mul_done),
    .prod_o  (w_mul_prod)
  );

  // Sequencing of mul and next-state of the EX/MEM register
  always_comb begin
    state_d    = state_q;
    memrd_d    = memrd_q;
    memwr_d    = memwr_q;
    memtoreg_d = memtoreg_q;
    regwrite_d = regwrite_q;
    result_d   = result_q;
    wrdata_d   = wrdata_q;
    rd_d       = rd_q;
    if (bus.start_i) begin
      case (state_q)
        c_S_IDLE: begin
          if (w_is_mul) begin
            // Bubble into MEM while the product is being built
            state_d    = c_S_MUL;
            memrd_d    = 1'b0;
            memwr_d    = 1'b0;
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            result_d   = '0;
            wrdata_d   = '0;
            rd_d       = '0;
          end else begin
            memrd_d    = bus.MemRd_i;
            memwr_d    = bus.MemWr_i;
            memtoreg_d = bus.MemtoReg_i;
            regwrite_d = bus.RegWrite_i;
            result_d   = w_alu_res;
            wrdata_d   = w_fwd_b;
            rd_d       = w_dst;
          end
        end
        c_S_MUL: begin
          if (w_mul_done) begin
            state_d = c_S_DONE;
          end else if (!w_mul_busy) begin
            state_d = c_S_IDLE;
          end
        end
        c_S_DONE: begin
          // ID/EX is still holding the mul thanks to the stall
          state_d    = c_S_IDLE;
          memrd_d    = bus.MemRd_i;
          memwr_d    = bus.MemWr_i;
          memtoreg_d = bus.MemtoReg_i;
          regwrite_d = bus.RegWrite_i;
          result_d   = w_mul_prod;
          wrdata_d   = w_fwd_b;
          rd_d       = w_dst;
        end
        default: state_d = c_S_IDLE;
      endcase
    end
  end

  // State and EX/MEM register update with synchronous clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= c_S_IDLE;
      memrd_q    <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      result_q   <= '0;
      wrdata_q   <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      memrd_q    <= memrd_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      result_q   <= result_d;
      wrdata_q   <= wrdata_d;
      rd_q       <= rd_d;
    end
  end

  // Hold upstream from mul detection until the last shift-add step
  assign bus.stall_o = rst_n_i &&
                       (((state_q == c_S_IDLE) && bus.start_i && w_is_mul) ||
                        (state_q == c_S_MUL));

  assign bus.MemRd_o     = memrd_q;
  assign bus.MemWr_o     = memwr_q;
  assign bus.MemtoReg_o  = memtoreg_q;
  assign bus.RegWrite_o  = regwrite_q;
  assign bus.ALUResult_o = result_q;
  assign bus.WrData_o    = wrdata_q;
  assign bus.Rd_o        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Purpose  : Directed scoreboard bench for ex_mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    bit          stall_only;
    logic        stall;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] mon_ctl;

  // Monitor: at each falling edge, compare every entry due this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        mon_e = exp_q[i];
        exp_q.delete(i);
        checks++;
        mon_ctl = {bus.MemRd_o, bus.MemWr_o, bus.MemtoReg_o, bus.RegWrite_o};
        if (mon_e.stall_only) begin
          if (bus.stall_o !== mon_e.stall) begin
            errors++;
            $display("FAIL %s cyc=%0d: stall_o=%b expected %b",
                     mon_e.name, cyc, bus.stall_o, mon_e.stall);
          end
        end else if (bus.ALUResult_o !== mon_e.res || bus.WrData_o !== mon_e.wd ||
                     bus.Rd_o !== mon_e.rd || mon_ctl !== mon_e.ctl) begin
          errors++;
          $display("FAIL %s cyc=%0d: got res=%h wd=%h rd=%0d ctl=%b expected res=%h wd=%h rd=%0d ctl=%b",
                   mon_e.name, cyc, bus.ALUResult_o, bus.WrData_o, bus.Rd_o, mon_ctl,
                   mon_e.res, mon_e.wd, mon_e.rd, mon_e.ctl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input int c, input string nm, input logic [31:0] res,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [3:0] ctl);
    exp_t e;
    e.cyc = c; e.name = nm; e.stall_only = 1'b0; e.stall = 1'b0;
    e.res = res; e.wd = wd; e.rd = rd; e.ctl = ctl;
    exp_q.push_back(e);
  endtask

  task automatic exp_stall(input int c, input string nm, input logic s);
    exp_t e;
    e.cyc = c; e.name = nm; e.stall_only = 1'b1; e.stall = s;
    e.res = '0; e.wd = '0; e.rd = '0; e.ctl = '0;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.ALUSrc_i = 0; bus.RegDst_i = 0; bus.MemRd_i = 0; bus.MemWr_i = 0;
    bus.MemtoReg_i = 0; bus.RegWrite_i = 0; bus.ALUOp_i = 2'b00;
    bus.Data1_i = 0; bus.Data2_i = 0; bus.imm_i = 0;
    bus.Rs_i = 0; bus.Rt_i = 0; bus.Rd_i = 0; bus.funct_i = 0;
    bus.WB_RegWrite_i = 0; bus.WB_Rd_i = 0; bus.WB_data_i = 0;
  endtask

  task automatic rand_inputs();
    bus.ALUSrc_i = 1'($urandom); bus.RegDst_i = 1'($urandom);
    bus.MemRd_i = 1'($urandom); bus.MemWr_i = 1'($urandom);
    bus.MemtoReg_i = 1'($urandom); bus.RegWrite_i = 1'($urandom);
    bus.ALUOp_i = 2'($urandom); bus.funct_i = 6'($urandom);
    bus.Data1_i = $urandom; bus.Data2_i = $urandom; bus.imm_i = $urandom;
    bus.Rs_i = 5'($urandom); bus.Rt_i = 5'($urandom); bus.Rd_i = 5'($urandom);
    bus.WB_RegWrite_i = 1'($urandom); bus.WB_Rd_i = 5'($urandom);
    bus.WB_data_i = $urandom;
  endtask

  task automatic set_instr(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic alusrc, input logic regdst,
                           input logic memrd, input logic memwr,
                           input logic memtoreg, input logic regwrite,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd);
    bus.ALUOp_i = aluop; bus.funct_i = funct; bus.ALUSrc_i = alusrc;
    bus.RegDst_i = regdst; bus.MemRd_i = memrd; bus.MemWr_i = memwr;
    bus.MemtoReg_i = memtoreg; bus.RegWrite_i = regwrite;
    bus.Data1_i = d1; bus.Data2_i = d2; bus.imm_i = imm;
    bus.Rs_i = rs; bus.Rt_i = rt; bus.Rd_i = rd;
  endtask

  // Issue the current single-cycle instruction and expect it one edge later
  task automatic issue(input string nm, input logic [31:0] res, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [3:0] ctl);
    exp_stall(cyc, {nm, "_stall"}, 1'b0);
    exp_out(cyc + 1, nm, res, wd, rd, ctl);
    tick();
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.start_i = 1'b1;

    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tick();
      exp_out(cyc, "reset_out", 32'd0, 32'd0, 5'd0, 4'b0000);
      exp_stall(cyc, "reset_stall", 1'b0);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
    exp_out(cyc, "idle_out", 32'd0, 32'd0, 5'd0, 4'b0000);

    // R-type add
    set_instr(2'b10, 6'b100000, 0, 1, 0, 0, 0, 1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    issue("add", 32'd12, 32'd7, 5'd3, 4'b0001);

    // Forwarding: put r4=0x10 into EX/MEM, r4=0x20 on MEM/WB
    set_instr(2'b00, 6'd0, 1, 1, 0, 0, 0, 1, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 5'd4);
    issue("seed_r4", 32'h10, 32'd0, 5'd4, 4'b0001);
    bus.WB_RegWrite_i = 1'b1; bus.WB_Rd_i = 5'd4; bus.WB_data_i = 32'h20;
    set_instr(2'b00, 6'd0, 1, 1, 0, 0, 0, 1, 32'h999, 32'h55, 32'd1, 5'd4, 5'd5, 5'd7);
    issue("fwd_exmem_prio", 32'h11, 32'h55, 5'd7, 4'b0001);
    set_instr(2'b00, 6'd0, 1, 1, 0, 0, 0, 1, 32'h999, 32'h55, 32'd1, 5'd4, 5'd5, 5'd8);
    issue("fwd_memwb", 32'h21, 32'h55, 5'd8, 4'b0001);

    // Store with forwarded store data
    bus.WB_Rd_i = 5'd6; bus.WB_data_i = 32'hAB;
    set_instr(2'b00, 6'd0, 1, 0, 0, 1, 0, 0, 32'h100, 32'h777, 32'd8, 5'd9, 5'd6, 5'd0);
    issue("store", 32'h108, 32'hAB, 5'd6, 4'b0100);
    bus.WB_RegWrite_i = 1'b0;

    // and / ori / subtract-class load / wrapping sub
    set_instr(2'b10, 6'b100100, 0, 1, 0, 0, 0, 1, 32'hF0F0, 32'hFF00, 32'd0, 5'd1, 5'd2, 5'd10);
    issue("and", 32'hF000, 32'hFF00, 5'd10, 4'b0001);
    set_instr(2'b11, 6'd0, 1, 0, 0, 0, 0, 1, 32'hF0, 32'd0, 32'h0F, 5'd11, 5'd15, 5'd0);
    issue("or_imm", 32'hFF, 32'd0, 5'd15, 4'b0001);
    set_instr(2'b01, 6'd0, 1, 0, 1, 0, 1, 1, 32'd10, 32'd0, 32'd3, 5'd1, 5'd16, 5'd0);
    issue("sub_aluop", 32'd7, 32'd0, 5'd16, 4'b1011);
    set_instr(2'b10, 6'b100010, 0, 1, 0, 0, 0, 1, 32'd0, 32'd1, 32'd0, 5'd2, 5'd3, 5'd17);
    issue("sub_wrap", 32'hFFFF_FFFF, 32'd1, 5'd17, 4'b0001);

    // mul 0xFFFFFFFF * 3; MEM/WB changes mid-multiply must not matter
    set_instr(2'b10, 6'b011000, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd12, 5'd13, 5'd14);
    for (int k = 0; k < 33; k++) begin
      exp_stall(cyc, "mul_stall", 1'b1);
      if (k == 0 || k == 20) exp_out(cyc + 1, "mul_bubble", 32'd0, 32'd0, 5'd0, 4'b0000);
      if (k == 5) begin
        bus.WB_RegWrite_i = 1'b1; bus.WB_Rd_i = 5'd12; bus.WB_data_i = 32'd5;
      end
      tick();
    end
    exp_stall(cyc, "mul_done_stall", 1'b0);
    exp_out(cyc, "mul_done_bubble", 32'd0, 32'd0, 5'd0, 4'b0000);
    exp_out(cyc + 1, "mul_result", 32'hFFFF_FFFD, 32'd3, 5'd14, 4'b0001);
    tick();

    // start_i low freezes EX/MEM
    bus.WB_RegWrite_i = 1'b0;
    bus.start_i = 1'b0;
    set_instr(2'b10, 6'b100000, 0, 1, 0, 0, 0, 1, 32'd1, 32'd2, 32'd0, 5'd18, 5'd19, 5'd22);
    issue("freeze_hold", 32'hFFFF_FFFD, 32'd3, 5'd14, 4'b0001);
    bus.start_i = 1'b1;
    issue("after_freeze", 32'd3, 32'd2, 5'd22, 4'b0001);

    // mul aborted by reset at MUL cycle 10
    set_instr(2'b10, 6'b011000, 0, 1, 0, 0, 0, 1, 32'd7, 32'd9, 32'd0, 5'd1, 5'd2, 5'd20);
    for (int k = 0; k < 10; k++) begin
      exp_stall(cyc, "abort_mul_stall", 1'b1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    exp_stall(cyc, "abort_stall", 1'b0);
    exp_out(cyc, "abort_out", 32'd0, 32'd0, 5'd0, 4'b0000);
    exp_out(cyc + 30, "abort_no_result", 32'd0, 32'd0, 5'd0, 4'b0000);
    repeat (31) tick();

    // slt signed both ways, unknown funct, operand B forward from EX/MEM
    set_instr(2'b10, 6'b101010, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3, 5'd4, 5'd21);
    issue("slt_neg_lt_pos", 32'd1, 32'd1, 5'd21, 4'b0001);
    set_instr(2'b10, 6'b101010, 0, 1, 0, 0, 0, 1, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5, 5'd6, 5'd23);
    issue("slt_pos_ge_neg", 32'd0, 32'hFFFF_FFFF, 5'd23, 4'b0001);
    set_instr(2'b10, 6'b111111, 0, 1, 0, 0, 0, 1, 32'd2, 32'd3, 32'd0, 5'd7, 5'd8, 5'd24);
    issue("funct_default_add", 32'd5, 32'd3, 5'd24, 4'b0001);
    set_instr(2'b10, 6'b100000, 0, 1, 0, 0, 0, 1, 32'd10, 32'd0, 32'd0, 5'd9, 5'd24, 5'd25);
    issue("fwd_b_exmem", 32'd15, 32'd5, 5'd25, 4'b0001);

    idle_inputs();
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
    tick();
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expected at cyc %0d never compared (now %0d)", mon_e.name, mon_e.cyc, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
